// File: rtl/readout_pkg.sv
// Shared definitions for the register readout streamer: default digit
// width, FSM state encodings and the counter sizing helper.
package readout_pkg;

    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest number of bits able to index 'value' distinct codes (min 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reg_readout.sv
// Reader side of the 16-bit load register. On start it snapshots the
// input word and streams it out one digit per valid/ready transfer, MSB
// digit first, then pulses done.
// Optional build macro SIGNED_EN: treat the word as two's complement,
// stream its magnitude and prefix a sign digit (NDIG+1 transfers).
module reg_readout
    import readout_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid,
    input  logic               ready,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CNT_W = clog2(NDIG + 1);
`ifdef SIGNED_EN
    localparam int NXFER = NDIG + 1;
`else
    localparam int NXFER = NDIG;
`endif
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NXFER - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT_W-1:0] r_digit;
    logic               r_valid;
    logic               r_last;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_shadow_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [DIGIT_W-1:0] w_digit_nxt;
    logic               w_valid_nxt;
    logic               w_last_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_accept;
    logic [WIDTH-1:0]   w_capture;
    logic [WIDTH-1:0]   w_shifted;

`ifdef SIGNED_EN
    // Sign flag and a marker that the sign digit is the one being presented.
    logic               r_sign;
    logic               r_sphase;
    logic               w_sign_nxt;
    logic               w_sphase_nxt;

    // Magnitude of the two's complement word; 0x8000 maps onto itself.
    assign w_capture = in[WIDTH-1] ? (~in + WIDTH'(1)) : in;
`else
    assign w_capture = in;
`endif

    assign w_shifted = r_shadow << DIGIT_W;
    assign w_accept  = r_valid && ready;

    // State register; the only place the FSM state changes.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and next-output decode from the current state.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_cnt;
        w_digit_nxt  = r_digit;
        w_valid_nxt  = 1'b0;
        w_last_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
`ifdef SIGNED_EN
        w_sign_nxt   = r_sign;
        w_sphase_nxt = r_sphase;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_SEND;
                    w_shadow_nxt = w_capture;
                    w_cnt_nxt    = CNT_INIT;
                    w_valid_nxt  = 1'b1;
                    w_last_nxt   = (CNT_INIT == '0);
`ifdef SIGNED_EN
                    w_sign_nxt   = in[WIDTH-1];
                    w_sphase_nxt = 1'b1;
                    w_digit_nxt  = DIGIT_W'(in[WIDTH-1]);
`else
                    w_digit_nxt  = w_capture[WIDTH-1 -: DIGIT_W];
`endif
                end
            end
            ST_SEND: begin
                // Without a transfer, digit/last/valid simply hold.
                w_valid_nxt = 1'b1;
                w_last_nxt  = r_last;
`ifdef SIGNED_EN
                if (r_sphase) begin
                    w_digit_nxt = DIGIT_W'(r_sign);
                end
`endif
                if (w_accept) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_DONE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt  = r_cnt - CNT_W'(1);
                        w_last_nxt = (r_cnt == CNT_W'(1));
`ifdef SIGNED_EN
                        if (r_sphase) begin
                            // Sign digit consumed; the unshifted MSB digit follows.
                            w_sphase_nxt = 1'b0;
                            w_digit_nxt  = r_shadow[WIDTH-1 -: DIGIT_W];
                        end else begin
                            w_shadow_nxt = w_shifted;
                            w_digit_nxt  = w_shifted[WIDTH-1 -: DIGIT_W];
                        end
`else
                        w_shadow_nxt = w_shifted;
                        w_digit_nxt  = w_shifted[WIDTH-1 -: DIGIT_W];
`endif
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                // Unused encoding: fall back to IDLE on the next edge.
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Datapath and registered outputs; nothing combinational reaches a port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_digit  <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SIGNED_EN
            r_sign   <= 1'b0;
            r_sphase <= 1'b0;
`endif
        end else begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_digit  <= w_digit_nxt;
            r_valid  <= w_valid_nxt;
            r_last   <= w_last_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
`ifdef SIGNED_EN
            r_sign   <= w_sign_nxt;
            r_sphase <= w_sphase_nxt;
`endif
        end
    end

    assign digit = r_digit;
    assign valid = r_valid;
    assign last  = r_last;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_reg_readout.sv
// Self-checking bench for reg_readout. Expected digit sequences come from
// an arithmetic model of the word (magnitude and sign under SIGNED_EN).
module tb_reg_readout;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_w;
    logic [3:0]  digit;
    logic        valid;
    logic        ready;
    logic        last;
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;

    logic [3:0] exp_q[$];

    reg_readout #(.WIDTH(16), .DIGIT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_w),
        .digit (digit),
        .valid (valid),
        .ready (ready),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Digit list for a word: plain base-16 arithmetic on its value.
    function automatic void build_expected(input logic [15:0] w);
        int unsigned val;
        exp_q.delete();
        val = w;
`ifdef SIGNED_EN
        if (val >= 32768) begin
            exp_q.push_back(4'd1);
            val = (65536 - val) % 65536;
        end else begin
            exp_q.push_back(4'd0);
        end
`endif
        for (int k = 3; k >= 0; k--) begin
            exp_q.push_back(4'((val / (16 ** k)) % 16));
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, 32'(digit), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_last"},  32'(last),  32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after done. pct = ready probability, poke = hold
    // start high (with in=0) while busy, stall_at/stall_len = forced
    // ready-low cycles while that digit index is presented.
    task automatic run_stream(input string tag, input logic [15:0] word, input int pct,
                              input bit poke, input int stall_at, input int stall_len);
        int idx;
        int cyc;
        int stalls;
        int n;
        build_expected(word);
        n = exp_q.size();
        idx = 0;
        cyc = 1;
        stalls = 0;
        in_w = word;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = poke;
        in_w = poke ? 16'h0000 : 16'($urandom);
        check({tag, "_latency_valid"}, 32'(valid), 32'd1);
        forever begin
            if (cyc > 400) begin
                check({tag, "_timeout"}, 32'(cyc), 32'd0);
                break;
            end
            if (valid) begin
                if (idx >= n) begin
                    check({tag, "_extra_digit"}, 32'(idx), 32'(n - 1));
                    break;
                end
                check({tag, "_digit"}, 32'(digit), 32'(exp_q[idx]));
                check({tag, "_last"},  32'(last),  32'(idx == n - 1));
                check({tag, "_busy"},  32'(busy),  32'd1);
                check({tag, "_nodone"}, 32'(done), 32'd0);
            end else begin
                check({tag, "_done"},  32'(done), 32'd1);
                check({tag, "_count"}, 32'(idx),  32'(n));
                check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
                break;
            end
            if (idx == stall_at && stalls < stall_len) begin
                ready = 1'b0;
                stalls++;
            end else begin
                ready = ($urandom_range(99) < pct);
            end
            if (ready) idx++;
            @(negedge clk);
            cyc++;
        end
        if (pct >= 100 && stall_len == 0) begin
            check({tag, "_done_cycle"}, 32'(cyc), 32'(n + 1));
        end
        // DONE cycle: start may still be high here and must be ignored.
        @(negedge clk);
        check({tag, "_idle_busy"},  32'(busy),  32'd0);
        check({tag, "_idle_valid"}, 32'(valid), 32'd0);
        check({tag, "_idle_done"},  32'(done),  32'd0);
        start = 1'b0;
        ready = 1'b1;
        in_w = 16'($urandom);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        in_w  = 16'h0000;

        // Reset state.
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Basic stream with ready held high.
        run_stream("basic", 16'hB1E7, 100, 1'b0, -1, 0);

        // Backpressure: ready low for three cycles on the second digit.
        run_stream("bp", 16'h1234, 100, 1'b0, 1, 3);

        // Start held high through SEND and DONE must not spawn a stream.
        run_stream("ignored", 16'hFFFF, 100, 1'b1, -1, 0);
        @(negedge clk);
        check("ignored_no_second_valid", 32'(valid), 32'd0);
        check("ignored_no_second_busy",  32'(busy),  32'd0);

        // Reset after the second transfer.
        build_expected(16'hABCD);
        in_w = 16'hABCD;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_first", 32'(digit), 32'(exp_q[0]));
        @(negedge clk);
        check("rst_second", 32'(digit), 32'(exp_q[1]));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_release");
        run_stream("after_rst", 16'h0001, 100, 1'b0, -1, 0);

        // Signed corner words (the model follows the build).
        run_stream("w_ffff", 16'hFFFF, 100, 1'b0, -1, 0);
        run_stream("w_8000", 16'h8000, 100, 1'b0, -1, 0);
        run_stream("w_0005", 16'h0005, 100, 1'b0, -1, 0);

        // Back-to-back: each start lands on the first idle cycle after done.
        run_stream("b2b_a", 16'h5A3C, 100, 1'b0, -1, 0);
        run_stream("b2b_b", 16'hC0DE, 100, 1'b0, -1, 0);
        run_stream("b2b_c", 16'h7FFF, 100, 1'b0, -1, 0);

        // Randomized words, ready patterns and start pokes.
        for (int i = 0; i < 30; i++) begin
            run_stream("rand", 16'($urandom), 30 + int'($urandom_range(70)),
                       1'($urandom_range(1)), int'($urandom_range(4)), int'($urandom_range(3)));
            if ($urandom_range(1) == 1) begin
                @(negedge clk);
                check("rand_gap_valid", 32'(valid), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
